// File: rtl/cpu6_trap_ctrl.sv
// cpu6_trap_ctrl: interrupt/trap and mret sequencer between EX, the IRQ lines and the CSR file.
// Latency: IRQ rise -> sync (1) -> PEND (1) -> TRAP (1+stall); mret -> MRET next cycle.
// Backpressure: a busy or empty EX holds the pending trap in PEND until a clean boundary.
module cpu6_trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tmr_irq,
  input  logic            ext_irq,
  input  logic            csr_mtie_r,
  input  logic            csr_meie_r,
  input  logic            csr_mstatus_mie_r,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic            ex_valid,
  input  logic            ex_busy,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_mret,
  output logic            tmr_irq_r,
  output logic            ext_irq_r,
  output logic            excp_mepc_ena,
  output logic [XLEN-1:0] excp_mepc,
  output logic            mret_ena,
  output logic            flush,
  output logic            redirect_ena,
  output logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    TRAP = 2'd2,
    MRET = 2'd3
  } state_t;

  state_t          state;
  logic            tmr_s;
  logic            ext_s;
  logic [XLEN-1:0] mepc_q;
  logic            cause_ext_q;

  logic take;
  logic ext_sel;
  logic bnd;

  assign ext_sel = ext_s & csr_meie_r;
  assign take    = csr_mstatus_mie_r & ((tmr_s & csr_mtie_r) | ext_sel);
  assign bnd     = ex_valid & ~ex_busy;

  // Single-stage capture of the raw interrupt levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_s <= 1'b0;
      ext_s <= 1'b0;
    end else begin
      tmr_s <= tmr_irq;
      ext_s <= ext_irq;
    end
  end

  // Trap/mret sequencer; mret wins in IDLE, a pending trap wins over mret in PEND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mepc_q      <= '0;
      cause_ext_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bnd && ex_mret) state <= MRET;
          else if (take)      state <= PEND;
        end
        PEND: begin
          if (!take) begin
            state <= IDLE;
          end else if (bnd) begin
            state       <= TRAP;
            mepc_q      <= ex_pc;
            cause_ext_q <= ext_sel;
          end
        end
        TRAP:    state <= IDLE;
        MRET:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore output decode; async reset of the state drops any pulse at once.
  always_comb begin
    tmr_irq_r     = 1'b0;
    ext_irq_r     = 1'b0;
    excp_mepc_ena = 1'b0;
    excp_mepc     = mepc_q;
    mret_ena      = 1'b0;
    flush         = 1'b0;
    redirect_ena  = 1'b0;
    redirect_pc   = '0;
    case (state)
      TRAP: begin
        excp_mepc_ena = 1'b1;
        ext_irq_r     = cause_ext_q;
        tmr_irq_r     = ~cause_ext_q;
        flush         = 1'b1;
        redirect_ena  = 1'b1;
        redirect_pc   = csr_mtvec;
      end
      MRET: begin
        mret_ena     = 1'b1;
        flush        = 1'b1;
        redirect_ena = 1'b1;
        redirect_pc  = csr_mepc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu6_trap_ctrl.sv
// Testbench for cpu6_trap_ctrl: directed vector table, reset corner, randomized run vs reference model.
// Outputs are compared 1 time unit after each rising edge.
// Summary line reports tests run and failures.
module tb_cpu6_trap_ctrl;

  localparam logic [31:0] MT = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        tmr_irq, ext_irq, csr_mtie_r, csr_meie_r, csr_mstatus_mie_r;
  logic [31:0] csr_mtvec, csr_mepc, ex_pc;
  logic        ex_valid, ex_busy, ex_mret;
  logic        tmr_irq_r, ext_irq_r, excp_mepc_ena, mret_ena, flush, redirect_ena;
  logic [31:0] excp_mepc, redirect_pc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cpu6_trap_ctrl #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .tmr_irq(tmr_irq), .ext_irq(ext_irq),
    .csr_mtie_r(csr_mtie_r), .csr_meie_r(csr_meie_r), .csr_mstatus_mie_r(csr_mstatus_mie_r),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .ex_valid(ex_valid), .ex_busy(ex_busy), .ex_pc(ex_pc), .ex_mret(ex_mret),
    .tmr_irq_r(tmr_irq_r), .ext_irq_r(ext_irq_r),
    .excp_mepc_ena(excp_mepc_ena), .excp_mepc(excp_mepc),
    .mret_ena(mret_ena), .flush(flush),
    .redirect_ena(redirect_ena), .redirect_pc(redirect_pc)
  );

  // {tmr_irq_r, ext_irq_r, mret_ena, excp_mepc_ena, flush, redirect_ena, redirect_pc, excp_mepc}
  logic [69:0] act;
  assign act = {tmr_irq_r, ext_irq_r, mret_ena, excp_mepc_ena, flush, redirect_ena, redirect_pc, excp_mepc};

  typedef struct {
    logic [7:0]  in;     // {tmr, ext, mie, mtie, meie, valid, busy, mret}
    logic [31:0] pc;
    logic [3:0]  pulse;  // {tmr_irq_r, ext_irq_r, mret_ena, excp_mepc_ena}
    logic [1:0]  fr;     // {flush, redirect_ena}
    logic [31:0] rpc;
    logic [31:0] mepc;
  } vec_t;

  vec_t tv[36];

  function automatic vec_t mk(logic [7:0] in, logic [31:0] pc, logic [3:0] pulse,
                              logic [1:0] fr, logic [31:0] rpc, logic [31:0] mepc);
    vec_t v;
    v.in = in; v.pc = pc; v.pulse = pulse; v.fr = fr; v.rpc = rpc; v.mepc = mepc;
    return v;
  endfunction

  task automatic check(input string name, input logic [69:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] in, input logic [31:0] pc);
    {tmr_irq, ext_irq, csr_mstatus_mie_r, csr_mtie_r, csr_meie_r, ex_valid, ex_busy, ex_mret} = in;
    ex_pc = pc;
  endtask

  // Reference model: pending flag, one-cycle trap/mret events, last sampled IRQ levels.
  logic        m_ts, m_es, m_pend, m_trap, m_mret, m_cause;
  logic [31:0] m_mepc;

  task automatic model_reset();
    m_ts = 0; m_es = 0; m_pend = 0; m_trap = 0; m_mret = 0; m_cause = 0; m_mepc = 0;
  endtask

  task automatic model_edge();
    logic en_ext, want, boundary;
    en_ext   = m_es & csr_meie_r;
    want     = csr_mstatus_mie_r & ((m_ts & csr_mtie_r) | en_ext);
    boundary = ex_valid & ~ex_busy;
    if (m_trap || m_mret) begin
      m_trap = 0; m_mret = 0;
    end else if (m_pend) begin
      if (!want) m_pend = 0;
      else if (boundary) begin
        m_pend = 0; m_trap = 1; m_mepc = ex_pc; m_cause = en_ext;
      end
    end else if (boundary && ex_mret) begin
      m_mret = 1;
    end else if (want) begin
      m_pend = 1;
    end
    m_ts = tmr_irq;
    m_es = ext_irq;
  endtask

  function automatic logic [69:0] model_out();
    logic [31:0] rp;
    rp = m_trap ? csr_mtvec : (m_mret ? csr_mepc : 32'h0);
    return {m_trap & ~m_cause, m_trap & m_cause, m_mret, m_trap, m_trap | m_mret, m_trap | m_mret, rp, m_mepc};
  endfunction

  initial begin
    reset = 1'b1;
    drive(8'h00, 32'h0);
    csr_mtvec = MT;
    csr_mepc  = 32'h480;

    // Timer trap
    tv[0]  = mk(8'b10110100, 32'h100, 4'b0000, 2'b00, 0,  0);
    tv[1]  = mk(8'b10110100, 32'h100, 4'b0000, 2'b00, 0,  0);
    tv[2]  = mk(8'b00110100, 32'h100, 4'b1001, 2'b11, MT, 32'h100);
    tv[3]  = mk(8'b00110100, 32'h100, 4'b0000, 2'b00, 0,  32'h100);
    tv[4]  = mk(8'b00110100, 32'h100, 4'b0000, 2'b00, 0,  32'h100);
    // External beats timer
    tv[5]  = mk(8'b11111100, 32'h200, 4'b0000, 2'b00, 0,  32'h100);
    tv[6]  = mk(8'b11111100, 32'h200, 4'b0000, 2'b00, 0,  32'h100);
    tv[7]  = mk(8'b11111100, 32'h200, 4'b0101, 2'b11, MT, 32'h200);
    tv[8]  = mk(8'b00111100, 32'h200, 4'b0000, 2'b00, 0,  32'h200);
    tv[9]  = mk(8'b00111100, 32'h200, 4'b0000, 2'b00, 0,  32'h200);
    // Busy stall: four busy cycles in PEND, trap on the cycle busy falls
    tv[10] = mk(8'b10111110, 32'h30,  4'b0000, 2'b00, 0,  32'h200);
    tv[11] = mk(8'b10111110, 32'h30,  4'b0000, 2'b00, 0,  32'h200);
    tv[12] = mk(8'b10111110, 32'h30,  4'b0000, 2'b00, 0,  32'h200);
    tv[13] = mk(8'b10111110, 32'h30,  4'b0000, 2'b00, 0,  32'h200);
    tv[14] = mk(8'b10111110, 32'h30,  4'b0000, 2'b00, 0,  32'h200);
    tv[15] = mk(8'b10111110, 32'h30,  4'b0000, 2'b00, 0,  32'h200);
    tv[16] = mk(8'b00111100, 32'h2C,  4'b1001, 2'b11, MT, 32'h2C);
    tv[17] = mk(8'b00111100, 32'h2C,  4'b0000, 2'b00, 0,  32'h2C);
    // Abandon by source drop
    tv[18] = mk(8'b10111110, 32'h40,  4'b0000, 2'b00, 0,  32'h2C);
    tv[19] = mk(8'b10111110, 32'h40,  4'b0000, 2'b00, 0,  32'h2C);
    tv[20] = mk(8'b00111110, 32'h40,  4'b0000, 2'b00, 0,  32'h2C);
    tv[21] = mk(8'b00111100, 32'h40,  4'b0000, 2'b00, 0,  32'h2C);
    tv[22] = mk(8'b00111100, 32'h40,  4'b0000, 2'b00, 0,  32'h2C);
    // Abandon by clearing global MIE
    tv[23] = mk(8'b10111110, 32'h40,  4'b0000, 2'b00, 0,  32'h2C);
    tv[24] = mk(8'b10111110, 32'h40,  4'b0000, 2'b00, 0,  32'h2C);
    tv[25] = mk(8'b10011100, 32'h40,  4'b0000, 2'b00, 0,  32'h2C);
    tv[26] = mk(8'b00011100, 32'h40,  4'b0000, 2'b00, 0,  32'h2C);
    // mret
    tv[27] = mk(8'b00011101, 32'h40,  4'b0010, 2'b11, 32'h480, 32'h2C);
    tv[28] = mk(8'b00011100, 32'h40,  4'b0000, 2'b00, 0,  32'h2C);
    // mret beats take in IDLE, trap beats mret in PEND
    tv[29] = mk(8'b10111100, 32'h50,  4'b0000, 2'b00, 0,  32'h2C);
    tv[30] = mk(8'b10111101, 32'h50,  4'b0010, 2'b11, 32'h480, 32'h2C);
    tv[31] = mk(8'b10111100, 32'h50,  4'b0000, 2'b00, 0,  32'h2C);
    tv[32] = mk(8'b10111100, 32'h50,  4'b0000, 2'b00, 0,  32'h2C);
    tv[33] = mk(8'b10111101, 32'h50,  4'b1001, 2'b11, MT, 32'h50);
    tv[34] = mk(8'b00111100, 32'h50,  4'b0000, 2'b00, 0,  32'h50);
    tv[35] = mk(8'b00111100, 32'h50,  4'b0000, 2'b00, 0,  32'h50);

    #1;
    check("reset_state", 70'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 36; i++) begin
      drive(tv[i].in, tv[i].pc);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {tv[i].pulse, tv[i].fr, tv[i].rpc, tv[i].mepc});
      @(negedge clk);
    end

    // Reset in the middle of a TRAP cycle
    drive(8'b10110100, 32'h60);
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_trap", {4'b1001, 2'b11, MT, 32'h60});
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_trap", 70'h0);
    @(negedge clk);
    drive(8'b00110100, 32'h60);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", 70'h0);

    // Randomized run against the reference model
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0)  tmr_irq = ~tmr_irq;
      if ($urandom_range(9) == 0)  ext_irq = ~ext_irq;
      if ($urandom_range(15) == 0) csr_mstatus_mie_r = ~csr_mstatus_mie_r;
      if ($urandom_range(15) == 0) csr_mtie_r = ~csr_mtie_r;
      if ($urandom_range(15) == 0) csr_meie_r = ~csr_meie_r;
      ex_valid  = ($urandom_range(3) != 0);
      ex_busy   = ($urandom_range(3) == 0);
      ex_mret   = ($urandom_range(7) == 0);
      ex_pc     = $urandom;
      csr_mtvec = $urandom;
      csr_mepc  = $urandom;
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("rand%0d", n), model_out());
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu6_trap_ctrl.md
# cpu6_trap_ctrl

Interrupt/trap sequencer that drives the trap-side inputs of the cpu6 machine-mode CSR block and consumes its enable outputs. It synchronises the raw timer and external interrupt lines, masks them with the CSR enables, waits for a clean instruction boundary in EX, and then issues a one-cycle trap. That trap writes mepc, clears mstatus.MIE, flushes the pipeline and redirects fetch to mtvec. It also sequences `mret`: a one-cycle `mret_ena` plus a redirect to mepc. The block sits between the EX stage, the interrupt sources and the CSR file.

## Interface
- XLEN, 32: data/address width (`CPU6_XLEN`).

- clk  in  1  core clock.
- reset  in  1  reset, asynchronous, active-high.
- tmr_irq  in  1  raw level timer interrupt.
- ext_irq  in  1  raw level external interrupt.
- csr_mtie_r  in  1  mie.MTIE from the CSR.
- csr_meie_r  in  1  mie.MEIE from the CSR.
- csr_mstatus_mie_r  in  1  global MIE from the CSR.
- csr_mtvec  in  XLEN  trap vector base.
- csr_mepc  in  XLEN  current mepc.
- ex_valid  in  1  valid instruction present in EX.
- ex_busy  in  1  EX instruction has a bus access in flight; it must not be killed.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_mret  in  1  EX instruction is `mret`.
- tmr_irq_r  out  1  one-cycle timer trap pulse to the CSR.
- ext_irq_r  out  1  one-cycle external trap pulse to the CSR.
- excp_mepc_ena  out  1  mepc write enable.
- excp_mepc  out  XLEN  value written to mepc.
- mret_ena  out  1  one-cycle `mret` commit to the CSR.
- flush  out  1  kill IF/ID/EX contents.
- redirect_ena  out  1  load fetch PC from `redirect_pc`.
- redirect_pc  out  XLEN  new fetch PC.

## Operation
- Synchroniser: `tmr_irq` and `ext_irq` are each registered once into `tmr_s` and `ext_s`.
- Take condition:
  - `take = csr_mstatus_mie_r & ((tmr_s & csr_mtie_r) | (ext_s & csr_meie_r))`.
  - Cause priority: external over timer (`ext_sel = ext_s & csr_meie_r`).
- Boundary condition: `bnd = ex_valid & ~ex_busy`.
- FSM states: IDLE, PEND, TRAP, MRET.
  - IDLE, when `bnd & ex_mret`: go to MRET. This branch has priority over `take`.
  - IDLE, otherwise when `take`: go to PEND.
  - PEND, when `~take`: go to IDLE. The interrupt dropped or was masked, so the pending trap is abandoned and no pulse is issued.
  - PEND, when `take & bnd`: go to TRAP.
    - Capture `mepc_q <= ex_pc` and `cause_ext_q <= ext_sel`.
    - This applies even if the EX instruction is `mret`; the interrupt kills it.
  - PEND, otherwise: stay in PEND.
  - TRAP: go to IDLE unconditionally (1 cycle).
  - MRET: go to IDLE unconditionally (1 cycle).
- Outputs are Moore outputs, decoded from the state register.
  - In TRAP:
    - `excp_mepc_ena = 1`, `excp_mepc = mepc_q`.
    - `ext_irq_r = cause_ext_q`, `tmr_irq_r = ~cause_ext_q`.
    - `flush = 1`, `redirect_ena = 1`, `redirect_pc = csr_mtvec`.
  - In MRET:
    - `mret_ena = 1`, `flush = 1`, `redirect_ena = 1`, `redirect_pc = csr_mepc`.
  - In IDLE and PEND: all outputs are 0.
    - `redirect_pc` is 0 in these states.
    - `excp_mepc` holds `mepc_q`.
- At most one of {`tmr_irq_r`, `ext_irq_r`, `mret_ena`} is high in any cycle. `excp_mepc_ena` is high only in TRAP.
- The CSR clears MIE at the clock edge that ends TRAP, so `take` is 0 in the following cycle and no double trap is possible.

## Timing
- Reset (async): state = IDLE; `tmr_s`, `ext_s`, `mepc_q`, `cause_ext_q` = 0; every output = 0.
  - Asserting reset while in TRAP or MRET drops all pulses immediately, without waiting for a clock edge.
- Interrupt latency, with `tmr_irq` rising before edge E0 and `bnd` = 1 throughout:
  - `tmr_s` = 1 after E0.
  - PEND after E1.
  - TRAP during the cycle between E2 and E3.
  - mstatus.MIE and mepc are updated at E3.
- Each cycle of `ex_busy` = 1 (or `ex_valid` = 0) while in PEND adds one cycle of latency.
- `mret` latency: `ex_mret & bnd` in cycle C gives MRET in cycle C+1. `redirect_pc` carries the `csr_mepc` value present in that cycle.
- Simultaneous events:
  - In IDLE, `mret` beats `take`. The interrupt is taken afterwards if it is still enabled once mret sets MIE.
  - In PEND, the trap beats `mret`.
- Source de-assertion or a CSR clear of MIE, MTIE or MEIE while in PEND returns the FSM to IDLE on the next edge.

## Test plan
- Timer trap:
  - Stimulus: `mstatus_mie` = 1, `mtie` = 1, `ex_valid` = 1, `ex_pc` = 0x100; pulse `tmr_irq` high.
  - Required: exactly one cycle with `tmr_irq_r` = 1, `excp_mepc_ena` = 1, `excp_mepc` = 0x100, `flush` = 1, `redirect_pc` = mtvec, 3 edges after the rise.
- Priority:
  - Stimulus: `tmr_irq` and `ext_irq` raised together, both enabled.
  - Required: `ext_irq_r` = 1, `tmr_irq_r` = 0.
- Busy stall:
  - Stimulus: `ex_busy` = 1 for 4 cycles in PEND, then 0 with `ex_pc` = 0x2C.
  - Required: TRAP asserts in the cycle after `ex_busy` falls, with `excp_mepc` = 0x2C.
- Abandon:
  - Stimulus: enter PEND with `ex_busy` = 1, then drop `tmr_irq` (or clear `csr_mstatus_mie_r`).
  - Required: FSM returns to IDLE with no pulse on any output.
- mret:
  - Stimulus: `ex_mret` = 1 with `ex_valid` = 1, `csr_mepc` = 0x480.
  - Required: one-cycle `mret_ena` = 1, `flush` = 1, `redirect_pc` = 0x480.
- Reset:
  - Stimulus: assert `reset` in the middle of the TRAP cycle.
  - Required: all outputs 0 immediately; FSM is in IDLE after reset is released.
